// File: rtl/baud_frame_timer.sv
// baud_frame_timer: times one serial frame of 7..12 bits from a runtime
// divisor. Emits a one-cycle bit_tick per bit, at bit boundaries in TX mode
// and at bit centres in RX mode. Supports pause via enable, abort, and
// rejection of an out-of-range divisor.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an accepted trigger; counters cleared
// RUN   | frame in progress; phase counts cycles within a bit
module baud_frame_timer #(
    parameter int DIV_W = 16,
    parameter int IDX_W = 4
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             enable,
    input  logic             abort,
    input  logic             rx_mode,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       data_bits,
    input  logic             parity_en,
    input  logic             stop2,
    output logic             bit_tick,
    output logic [IDX_W-1:0] bit_idx,
    output logic             busy,
    output logic             finish,
    output logic             cfg_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    // start + 5 data + stop, minus one: the last index of the shortest frame
    localparam logic [IDX_W-1:0] IDX_BASE = IDX_W'(6);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_l_q, div_l_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [IDX_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             tick_q, tick_d;
    logic             finish_q, finish_d;
    logic             cfg_err_q, cfg_err_d;

    logic             start_req;
    logic             div_ok;
    logic             phase_wrap;
    logic [IDX_W-1:0] frame_last;

    assign start_req  = trigger && enable;
    assign div_ok     = (div >= DIV_MIN);
    assign phase_wrap = (phase_q == (div_l_q - DIV_ONE));
    // Frame fields are folded into the last bit index once, at accept time
    assign frame_last = IDX_BASE + IDX_W'(data_bits) + IDX_W'(parity_en)
                        + IDX_W'(stop2);

    // Next-state, counter and output-pulse logic
    always_comb begin
        state_d    = state_q;
        div_l_d    = div_l_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        last_idx_d = last_idx_q;
        bit_idx_d  = '0;
        tick_d     = 1'b0;
        finish_d   = 1'b0;
        cfg_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    if (div_ok) begin
                        state_d    = S_RUN;
                        div_l_d    = div;
                        bit_cnt_d  = '0;
                        last_idx_d = frame_last;
                        // RX starts half a bit in so ticks land mid-bit
                        phase_d    = rx_mode ? (div >> 1) : '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    phase_d   = '0;
                    bit_cnt_d = '0;
                end else if (enable) begin
                    if (phase_wrap) begin
                        phase_d   = '0;
                        tick_d    = 1'b1;
                        bit_idx_d = bit_cnt_q;
                        bit_cnt_d = bit_cnt_q + IDX_ONE;
                        if (bit_cnt_q == last_idx_q) begin
                            finish_d  = 1'b1;
                            state_d   = S_IDLE;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        phase_d = phase_q + DIV_ONE;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                phase_d   = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // State, counters and registered output pulses
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_l_q    <= '0;
            phase_q    <= '0;
            bit_cnt_q  <= '0;
            last_idx_q <= '0;
            bit_idx_q  <= '0;
            tick_q     <= 1'b0;
            finish_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_l_q    <= div_l_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            last_idx_q <= last_idx_d;
            bit_idx_q  <= bit_idx_d;
            tick_q     <= tick_d;
            finish_q   <= finish_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign bit_tick = tick_q;
    assign bit_idx  = bit_idx_q;
    assign busy     = (state_q == S_RUN);
    assign finish   = finish_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: doc/baud_frame_timer.md
Name: baud_frame_timer

Overview:
Parametrised successor to the UART baud/bit-timing generator. On a trigger it times one serial frame of programmable length, pulsing `bit_tick` once per bit with the bit index.
- TX mode: ticks fall at bit boundaries.
- RX mode: ticks fall at bit centres, for sampling.
- Adds a runtime divisor, 5–8 data bits, optional parity, 1/2 stop bits, abort, pause-via-enable and config-error flagging.
- Sits between the UART TX/RX shifters and the CPU peripheral bus.

Parameters:
- DIV_W, 16, width of the clock-divisor input and phase counter.
- IDX_W, 4, width of `bit_idx`; must hold 11, the maximum frame index.

Ports:
- sysclk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- trigger  in  1  frame start request; sampled only when idle and `enable`=1.
- enable  in  1  when 0: trigger ignored and the running frame paused (counters hold).
- abort  in  1  synchronous frame cancel.
- rx_mode  in  1  0 = TX (boundary ticks), 1 = RX (mid-bit ticks); latched at start.
- div  in  DIV_W  sysclk cycles per bit; latched at start; valid range ≥2.
- data_bits  in  2  0..3 selects 5..8 data bits; latched at start.
- parity_en  in  1  adds one parity bit; latched at start.
- stop2  in  1  0 = one stop bit, 1 = two stop bits; latched at start.
- bit_tick  out  1  one-cycle pulse per bit.
- bit_idx  out  IDX_W  index of the bit being ticked; valid when `bit_tick`=1.
- busy  out  1  frame in progress.
- finish  out  1  one-cycle pulse on normal frame completion.
- cfg_err  out  1  one-cycle pulse when a trigger is rejected because `div`<2.

Behaviour:
- Reset (asynchronous, any time including mid-frame): state IDLE; `bit_tick`, `bit_idx`, `busy`, `finish`, `cfg_err` all 0; phase counter and bit counter 0.
- States: IDLE, RUN.
- IDLE → RUN when `trigger`=1, `enable`=1 and `div`≥2, at that edge (the accept edge):
  - latch `div_l`, `rx_mode`, `data_bits`, `parity_en`, `stop2`;
  - bit counter = 0;
  - phase = 0 in TX mode, or `div_l>>1` in RX mode;
  - `busy`=1 from the following cycle.
- Config error: `trigger`=1, `enable`=1 and `div`<2 in IDLE → `cfg_err`=1 for one cycle; stay IDLE.
- Frame length N = 1 + (5 + `data_bits`) + `parity_en` + 1 + `stop2`. Range 7..12.
- In RUN with `enable`=1:
  - phase increments each edge;
  - when phase = `div_l`−1: phase → 0, `bit_tick`=1 and `bit_idx`=bit counter for the next cycle, bit counter increments.
- Tick spacing:
  - TX: first tick `div_l` cycles after the accept edge, then every `div_l`.
  - RX: first tick `div_l`−(`div_l`>>1) cycles after the accept edge, then every `div_l`.
- In RUN with `enable`=0: phase and bit counter hold; no tick. Every later tick is delayed by exactly the number of paused cycles.
- Completion: the tick with `bit_idx`=N−1 is accompanied by `finish`=1 in the same cycle, and `busy`=0 in that cycle; the state returns to IDLE.
  - A trigger present in that cycle is accepted, giving back-to-back frames.
- `abort`=1 in RUN (highest priority over tick and finish at that edge):
  - → IDLE, `busy`=0 next cycle;
  - no tick, no finish;
  - counters cleared.
  - `abort` in IDLE has no effect.
- Trigger while `busy`=1: ignored, with no queuing and no `cfg_err`.
- Changes to `div` and the frame fields mid-frame: no effect until the next accept.
- Phase arithmetic: DIV_W-bit unsigned, compared against `div_l`−1. `div` = 2^DIV_W−1 is legal.

Test Plan:
1. `div`=10, TX, `data_bits`=3, `parity_en`=0, `stop2`=0 (N=10); trigger accepted at cycle 0 → ticks at cycles 10,20,…,100 with `bit_idx` 0..9; `finish` with the cycle-100 tick; `busy` 1 over cycles 1..99.
2. `div`=10, RX, `data_bits`=0, `parity_en`=1, `stop2`=1 (N=9) → ticks at 5,15,…,85 with `bit_idx` 0..8; `finish` at 85.
3. Case 1 with `enable`=0 during cycles 33..39 → ticks at 10,20,30,47,57,…,107; `finish` at 107.
4. Case 1 with `abort` at cycle 37 → `busy`=0 from 38; no further `bit_tick`/`finish`; a new trigger at 50 gives its first tick at 60.
5. `div`=1 with trigger → `cfg_err` one cycle, `busy` stays 0. Trigger at cycle 55 of a running frame is ignored. Trigger held in the `finish` cycle starts a new frame whose first tick is 10 cycles later.
6. `reset` asserted asynchronously at cycle 42 of case 1 → all outputs 0 immediately; no tick or finish until the next accepted trigger after reset release.
